float_scalar_vector_mult_stream: RTL and testbench
==================================================

Name: float_scalar_vector_mult_stream

Overview:
- Streaming successor to the fixed scalar-times-line multiplier.
- Multiplies each incoming line of VALUES_PER_LINE IEEE-754 single-precision floats by a scalar that is latched once per job.
- Adds a job FSM (start, line count, done), valid/ready backpressure on both sides, and a credit-guarded output FIFO, so the non-stallable float_mult pipeline never overruns.
- Sits between a line reader and a line writer in the compute datapath.

Parameters:
- VALUES_PER_LINE, 16, floats per line; line width is 32*VALUES_PER_LINE.
- MULT_LATENCY, 5, float_mult pipeline depth in cycles; must equal the instantiated float_mult.
- FIFO_DEPTH, 8, output FIFO entries, in lines; must be >= MULT_LATENCY+2, enforced by an elaboration check.
- COUNT_WIDTH, 32, width of the line counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- scalar  in  32  float scalar; sampled on the accepted start.
- num_lines  in  COUNT_WIDTH  lines in the job; sampled on the accepted start.
- in_vector  in  32*VALUES_PER_LINE  input line.
- in_valid  in  1  input line valid.
- in_ready  out  1  block accepts a line this cycle.
- out_result  out  32*VALUES_PER_LINE  product line.
- out_valid  out  1  product line valid.
- out_ready  in  1  consumer accepts the product line.
- busy  out  1  high while in RUN or DRAIN.
- done  out  1  one-cycle pulse at job end.
- lines_done  out  COUNT_WIDTH  product lines emitted in the current or last job.

Behaviour:
- Reset asserted (reset=0):
  - State goes to IDLE; all counters and FIFO pointers clear.
  - in_ready=0, out_valid=0, busy=0, done=0, lines_done=0.
  - out_result reads 0.
  - float_mult instances receive ~reset; in-flight products are discarded and never appear after reset.
- FSM states IDLE, RUN, DRAIN:
  - IDLE, start=1: latch scalar and num_lines, clear counters, go to RUN. If num_lines==0, stay in IDLE and pulse done next cycle.
  - RUN: accept lines. When the accepted count reaches num_lines, go to DRAIN.
  - DRAIN: when lines_done reaches num_lines, pulse done and return to IDLE.
  - start outside IDLE is ignored.
- Credit counter occ (lines in flight plus FIFO contents, range 0..FIFO_DEPTH):
  - +1 on input accept; -1 on output pop.
  - Accept and pop in the same cycle leave occ unchanged.
- in_ready = (state==RUN) && (occ < FIFO_DEPTH) && (accepted < num_lines).
  - Combinational from registered state; does not depend on in_valid.
- Accept happens when in_valid && in_ready.
  - in_vector feeds all float_mult in1/in2 lanes, with in_valid gated by accept.
  - FIFO write occurs on float_mult q_valid of lane 0.
- Output side:
  - out_valid = FIFO not empty; out_result = FIFO head.
  - Pop happens when out_valid && out_ready; lines_done increments on each pop.
  - Pop is allowed in any state, so lines from a finished job drain even after reset-free abort is impossible.
- Latency: a line accepted at cycle t, with the FIFO empty, gives out_valid=1 at cycle t+MULT_LATENCY+1.
  - Throughput is 1 line/cycle while out_ready stays high.
- Backpressure:
  - With out_ready held low, at most FIFO_DEPTH lines are accepted, then in_ready=0.
  - The FIFO never overflows or drops data.
- Ordering: output order equals input order.
- Arithmetic: per lane, the float_mult result. This block does no rounding or special-case handling of its own (NaN, Inf and denormals pass through float_mult semantics).
- FIFO wrap-around: pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished. Simultaneous push and pop when full is legal (occ bounds it).

Decomposition:
- Package float_stream_pkg:
  - typedef float_t (logic [31:0]).
  - typedef state enum {IDLE, RUN, DRAIN}.
  - constants FLOAT_ONE=32'h3F800000 and FLOAT_ZERO, used by benches.
- Sub-modules:
  - one natural sub-module, line_fifo (parametrised width and depth, registered head, async active-low reset);
  - float_mult reused unchanged, one instance per lane via generate.

Test Plan:
- Single line: start, scalar=0x40000000 (2.0), num_lines=1, all lanes 0x3FC00000 (1.5) -> every lane 0x40400000 (3.0) at accept+MULT_LATENCY+1; done pulses one cycle after the pop; lines_done=1.
- Streaming: num_lines=64, in_valid and out_ready held high, lane i = float(i) -> 64 consecutive out_valid cycles with no bubble after the first; lane i = 2*i in order; done once.
- Backpressure: num_lines=20, out_ready=0 -> in_ready drops after exactly FIFO_DEPTH=8 accepts; release out_ready -> all 20 lines out in order, none lost or duplicated.
- Random out_ready (50%) and random in_valid, num_lines=200 -> a scoreboard matches all 200 lines; occ never exceeds 8.
- Zero-length job plus ignored start: num_lines=0 -> done pulse, in_ready never high. Start asserted during RUN -> scalar and num_lines unchanged.
- Reset mid-job: assert reset=0 with 3 lines in flight -> outputs return to their reset values immediately; after release, no stale out_valid appears. A fresh job completes correctly.

Source files
------------

// File: rtl/float_stream_pkg.sv
// Shared types and constants for the streaming scalar-times-line multiplier.
//   float_t  : raw IEEE-754 single-precision bit pattern
//   state_t  : job FSM state (IDLE / RUN / DRAIN)
//   FLOAT_*  : handy bit patterns for stimulus and special-case results
package float_stream_pkg;

   typedef logic [31:0] float_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam float_t FLOAT_ONE  = 32'h3F800000;
   localparam float_t FLOAT_ZERO = 32'h00000000;
   localparam float_t FLOAT_QNAN = 32'h7FC00000;

endpackage

// File: rtl/float_mult.sv
// Pipelined single-precision multiplier, LATENCY cycles from in_valid to q_valid.
// Not stallable: every accepted operand pair emerges exactly LATENCY cycles later.
//   clk, reset (async, active-high)
//   in1, in2, in_valid : operands
//   q, q_valid         : product
// Round-to-nearest-even; denormal inputs and results flush to signed zero;
// any NaN result is the canonical quiet NaN.
module float_mult
   import float_stream_pkg::*;
#(
   parameter int LATENCY = 5
)(
   input  logic   clk,
   input  logic   reset,
   input  float_t in1,
   input  float_t in2,
   input  logic   in_valid,
   output float_t q,
   output logic   q_valid
);

   generate
      if (LATENCY < 3) begin : g_lat_chk
         $error("float_mult: LATENCY must be at least 3");
      end
   endgenerate

   logic [LATENCY:1] vld_pipe;

   // stage 1: registered operands
   float_t a, b;
   logic   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_zero = (a[30:23] == 8'd0);
   assign b_zero = (b[30:23] == 8'd0);
   assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

   // stage 2: raw significand product, unbiased exponent sum, special flags
   logic              s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [9:0] s2_exp;
   logic [47:0]       s2_prod;

   // stage 3: normalise + round, then plain delay to LATENCY
   logic              norm_hi, guard, sticky, round_up;
   logic [22:0]       frac;
   logic [23:0]       frac_r;
   logic signed [9:0] exp_n, exp_r;
   float_t            res;
   float_t            dly [3:LATENCY];

   always_comb begin
      norm_hi  = s2_prod[47];
      frac     = norm_hi ? s2_prod[46:24] : s2_prod[45:23];
      guard    = norm_hi ? s2_prod[23]    : s2_prod[22];
      sticky   = norm_hi ? |s2_prod[22:0] : |s2_prod[21:0];
      exp_n    = s2_exp + (norm_hi ? 10'sd1 : 10'sd0);
      round_up = guard & (sticky | frac[0]);
      // a rounding carry out of the fraction leaves frac_r[22:0] zero
      frac_r   = {1'b0, frac} + {23'd0, round_up};
      exp_r    = exp_n + (frac_r[23] ? 10'sd1 : 10'sd0);
      if (s2_nan)
         res = FLOAT_QNAN;
      else if (s2_inf || exp_r >= 10'sd255)
         res = {s2_sign, 8'hFF, 23'd0};
      else if (s2_zero || exp_r <= 10'sd0)
         res = {s2_sign, 31'd0};
      else
         res = {s2_sign, exp_r[7:0], frac_r[22:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         a        <= '0;
         b        <= '0;
         s2_sign  <= 1'b0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_exp   <= '0;
         s2_prod  <= '0;
         for (int k = 3; k <= LATENCY; k++) dly[k] <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
         a        <= in1;
         b        <= in2;
         s2_sign  <= a[31] ^ b[31];
         s2_nan   <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
         s2_inf   <= a_inf | b_inf;
         s2_zero  <= a_zero | b_zero;
         s2_exp   <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
         s2_prod  <= {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
         dly[3]   <= res;
         for (int k = 4; k <= LATENCY; k++) dly[k] <= dly[k-1];
      end
   end

   assign q       = dly[LATENCY];
   assign q_valid = vld_pipe[LATENCY];

endmodule

// File: rtl/line_fifo.sv
// Line FIFO for product lines.
//   clk, reset (async, active-low)
//   push, push_data : write side
//   pop             : read side, advances head when not empty
//   head, not_empty : current head entry and its valid
// Pointers carry one extra wrap bit so full and empty are distinct. A push
// while full is taken only together with a pop (the upstream credit
// counter keeps that the only way it can happen).
module line_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if ((1 << AW) != DEPTH) begin : g_depth_chk
         $error("line_fifo: DEPTH must be a power of two");
      end
   endgenerate

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty, full, do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // head comes straight from the storage registers, so it reads 0 out of reset
   assign head      = mem[rd_ptr[AW-1:0]];
   assign not_empty = !empty;

endmodule

// File: rtl/float_scalar_vector_mult_stream.sv
// Streaming scalar-times-line multiplier with a job FSM.
//   clk, reset (async, active-low)
//   start, scalar, num_lines : job setup, sampled when start is taken in IDLE
//   in_vector/in_valid/in_ready     : input line handshake
//   out_result/out_valid/out_ready  : product line handshake
//   busy (RUN or DRAIN), done (one-cycle pulse), lines_done (lines popped)
// Every lane multiplies by the latched scalar. The multiplier pipe cannot
// stall, so a credit counter (lines in flight + lines queued) stops input
// once the output FIFO could not absorb everything already in the pipe.
module float_scalar_vector_mult_stream
   import float_stream_pkg::*;
#(
   parameter int VALUES_PER_LINE = 16,
   parameter int MULT_LATENCY    = 5,
   parameter int FIFO_DEPTH      = 8,
   parameter int COUNT_WIDTH     = 32
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [31:0]                    scalar,
   input  logic [COUNT_WIDTH-1:0]         num_lines,
   input  logic [32*VALUES_PER_LINE-1:0]  in_vector,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [32*VALUES_PER_LINE-1:0]  out_result,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           done,
   output logic [COUNT_WIDTH-1:0]         lines_done
);

   localparam int LW    = 32 * VALUES_PER_LINE;
   localparam int CW    = COUNT_WIDTH;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   generate
      if (FIFO_DEPTH < MULT_LATENCY + 2) begin : g_depth_chk
         $error("FIFO_DEPTH must be >= MULT_LATENCY+2");
      end
   endgenerate

   state_t             state, state_nxt;
   float_t             scalar_q;
   logic [CW-1:0]      num_q, accepted;
   logic [OCC_W-1:0]   occ;
   logic               zero_done, job_start, accept, pop;
   logic [VALUES_PER_LINE-1:0] lane_qv;
   logic [LW-1:0]      prod_line;
   logic               unused_qv;

   assign job_start = start && (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && num_lines != '0) state_nxt = RUN;
         RUN:     if (accept && (accepted + CW'(1)) == num_q) state_nxt = DRAIN;
         DRAIN:   if (lines_done == num_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_ready = (state == RUN) && (occ < OCC_W'(FIFO_DEPTH)) && (accepted < num_q);
      busy     = (state != IDLE);
      // zero_done covers the empty job, which never leaves IDLE
      done     = zero_done || ((state == DRAIN) && (lines_done == num_q));
   end

   // ---- job registers and counters ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scalar_q   <= '0;
         num_q      <= '0;
         accepted   <= '0;
         lines_done <= '0;
         occ        <= '0;
         zero_done  <= 1'b0;
      end else begin
         zero_done <= job_start && (num_lines == '0);
         if (job_start) begin
            scalar_q   <= scalar;
            num_q      <= num_lines;
            accepted   <= '0;
            lines_done <= '0;
         end else begin
            if (accept) accepted   <= accepted + CW'(1);
            if (pop)    lines_done <= lines_done + CW'(1);
         end
         case ({accept, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // ---- one multiplier per lane ----
   for (genvar i = 0; i < VALUES_PER_LINE; i++) begin : g_lane
      float_mult #(.LATENCY(MULT_LATENCY)) u_mult (
         .clk      (clk),
         .reset    (~reset),
         .in1      (in_vector[32*i +: 32]),
         .in2      (scalar_q),
         .in_valid (accept),
         .q        (prod_line[32*i +: 32]),
         .q_valid  (lane_qv[i])
      );
   end

   // all lanes share one valid; lane 0 stands for the line
   assign unused_qv = ^lane_qv;

   line_fifo #(.WIDTH(LW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (lane_qv[0]),
      .push_data (prod_line),
      .pop       (pop),
      .head      (out_result),
      .not_empty (out_valid)
   );

endmodule

// File: tb/tb_float_scalar_vector_mult_stream.sv
// Bench for float_scalar_vector_mult_stream: table of single-line products,
// streaming / backpressure / random-handshake jobs checked by a scoreboard,
// plus zero-length job, ignored mid-job start and mid-job reset sequences.
module tb_float_scalar_vector_mult_stream;
   import float_stream_pkg::*;

   localparam int V  = 16;
   localparam int LW = 32 * V;
   localparam int FD = 8;
   localparam int ML = 5;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, out_ready;
   logic [31:0]   scalar, num_lines;
   logic [LW-1:0] in_vector, out_result;
   logic          in_ready, out_valid, busy, done;
   logic [31:0]   lines_done;

   float_scalar_vector_mult_stream dut (
      .clk(clk), .reset(reset), .start(start), .scalar(scalar), .num_lines(num_lines),
      .in_vector(in_vector), .in_valid(in_valid), .in_ready(in_ready),
      .out_result(out_result), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .lines_done(lines_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { float_t scal; float_t a; float_t res; } vec_t;
   vec_t tab [9];

   logic [LW-1:0] sb [$];
   logic [LW-1:0] cur_exp, exp_l;
   float_t        tab_a, tab_res;
   int  n_tests = 0, n_fail = 0;
   int  pop_cnt, done_cnt, acc_cnt, first_pop_cyc, last_pop_cyc, first_acc_cyc, done_cyc, acc_at_hold;
   bit  acc, saw_ready, saw_valid, occ_viol, rdy_at_hold, last_rdy;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   function automatic float_t i2f(input int unsigned v);
      int p;
      logic [31:0] m;
      if (v == 0) return FLOAT_ZERO;
      p = 31;
      while (!v[p]) p--;
      m = v << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   // exact for normal operands well below the overflow range
   function automatic float_t times2(input float_t x);
      if (x[30:23] == 8'd0) return {x[31], 31'd0};
      return {x[31], x[30:23] + 8'd1, x[22:0]};
   endfunction

   task automatic make_line(input int kind, input int li);
      float_t x;
      for (int i = 0; i < V; i++) begin
         case (kind)
            0:       x = i2f(int'(li * V + i));
            1:       x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 200)), 23'($urandom)};
            default: x = tab_a;
         endcase
         in_vector[32*i +: 32] = x;
         cur_exp[32*i +: 32]   = (kind == 2) ? tab_res : times2(x);
      end
   endtask

   task automatic clear_stats();
      pop_cnt = 0; done_cnt = 0; acc_cnt = 0; first_pop_cyc = 0; last_pop_cyc = 0;
      first_acc_cyc = 0; done_cyc = 0; acc_at_hold = 0; saw_ready = 0; saw_valid = 0;
      occ_viol = 0; rdy_at_hold = 0; sb.delete();
   endtask

   // One clock: observe at the falling edge, then return just after the rising edge.
   task automatic step();
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_line: got %0h expected no line", out_result);
         end else begin
            exp_l = sb.pop_front();
            chk("line_data", out_result, exp_l);
         end
         pop_cnt++;
         if (pop_cnt == 1) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (in_ready)  saw_ready = 1;
      if (out_valid) saw_valid = 1;
      last_rdy = in_ready;
      acc = in_valid && in_ready;
      if (acc) begin
         sb.push_back(cur_exp);
         acc_cnt++;
         if (acc_cnt == 1) first_acc_cyc = cyc;
      end
      if (sb.size() > FD) occ_viol = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int n, input float_t scal, input int kind, input int in_pct,
                          input int out_pct, input int hold, input bit mid_start);
      int li = 0, k = 0;
      clear_stats();
      start = 1; scalar = scal; num_lines = n;
      step();
      start = 0;
      while (done_cnt == 0 && k < 20 * n + 200) begin
         start = 0;
         if (mid_start && k == 2) begin start = 1; scalar = 32'h40800000; num_lines = 1; end
         if (!in_valid && li < n && $urandom_range(0, 99) < in_pct) begin
            make_line(kind, li);
            in_valid = 1;
         end
         out_ready = (k >= hold) && ($urandom_range(0, 99) < out_pct);
         step();
         if (k == hold - 1) begin acc_at_hold = acc_cnt; rdy_at_hold = last_rdy; end
         if (acc) begin in_valid = 0; li++; end
         k++;
      end
      start = 0; in_valid = 0; out_ready = 0;
      if (done_cnt == 0) fail_now("job_done_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{32'h40000000, 32'h3FC00000, 32'h40400000};  // 2 * 1.5 = 3
      tab[1] = '{32'h40400000, 32'h40400000, 32'h41100000};  // 3 * 3 = 9
      tab[2] = '{32'h40800000, 32'hC0200000, 32'hC1200000};  // 4 * -2.5 = -10
      tab[3] = '{32'h40400000, 32'h3F8CCCCD, 32'h40533334};  // 3 * 1.1, tie rounds to even
      tab[4] = '{32'h40000000, 32'h7F000000, 32'h7F800000};  // overflow -> +Inf
      tab[5] = '{FLOAT_ONE,    32'h80000000, 32'h80000000};  // 1 * -0 = -0
      tab[6] = '{32'h40000000, 32'h7FC00000, 32'h7FC00000};  // NaN propagates
      tab[7] = '{FLOAT_ZERO,   32'h7F800000, 32'h7FC00000};  // 0 * Inf = NaN
      tab[8] = '{32'hBF800000, FLOAT_ONE,    32'hBF800000};  // -1 * 1 = -1

      reset = 0; start = 0; scalar = 0; num_lines = 0; in_vector = '0;
      in_valid = 0; out_ready = 0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lines_done", lines_done, 0);
      chk("rst_out_result", out_result, 0);
      @(posedge clk);
      #1 reset = 1;

      // single-line jobs from the table
      for (int t = 0; t < 9; t++) begin
         tab_a = tab[t].a;
         tab_res = tab[t].res;
         run_job(1, tab[t].scal, 2, 100, 100, 0, 0);
         chk("tab_pops", pop_cnt, 1);
         chk("tab_latency", first_pop_cyc - first_acc_cyc, ML + 1);
         chk("tab_done_after_pop", done_cyc - last_pop_cyc, 1);
         chk("tab_lines_done", lines_done, 1);
      end

      // full-rate streaming
      run_job(64, 32'h40000000, 0, 100, 100, 0, 0);
      chk("stream_pops", pop_cnt, 64);
      chk("stream_no_bubble", last_pop_cyc - first_pop_cyc, 63);
      chk("stream_done_once", done_cnt, 1);
      chk("stream_sb_empty", sb.size(), 0);

      // output stalled for 30 cycles
      run_job(20, 32'h40000000, 1, 100, 100, 30, 0);
      chk("bp_accepts_held", acc_at_hold, FD);
      chk("bp_ready_low", rdy_at_hold, 0);
      chk("bp_pops", pop_cnt, 20);
      chk("bp_sb_empty", sb.size(), 0);
      chk("bp_lines_done", lines_done, 20);

      // random handshakes on both sides
      run_job(200, 32'h40000000, 1, 60, 50, 0, 0);
      chk("rnd_pops", pop_cnt, 200);
      chk("rnd_sb_empty", sb.size(), 0);
      chk("rnd_occ_bound", occ_viol, 0);
      chk("rnd_done_once", done_cnt, 1);

      // zero-length job
      clear_stats();
      start = 1; scalar = 32'h40000000; num_lines = 0;
      step();
      start = 0;
      step();
      chk("zero_done_next", done_cnt, 1);
      repeat (3) step();
      chk("zero_done_once", done_cnt, 1);
      chk("zero_never_ready", saw_ready, 0);
      chk("zero_not_busy", busy, 0);

      // a start during RUN must not touch scalar or line count
      run_job(6, 32'h40000000, 1, 70, 100, 0, 1);
      chk("mid_start_pops", pop_cnt, 6);
      chk("mid_start_lines_done", lines_done, 6);
      chk("mid_start_sb_empty", sb.size(), 0);

      // reset with three lines inside the multiplier pipe
      clear_stats();
      start = 1; scalar = 32'h40000000; num_lines = 10;
      step();
      start = 0;
      for (int k = 0; k < 50 && acc_cnt < 3; k++) begin
         if (!in_valid) begin make_line(1, acc_cnt); in_valid = 1; end
         step();
         if (acc) in_valid = 0;
      end
      in_valid = 0;
      if (acc_cnt != 3) fail_now("rst_fill");
      reset = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_lines_done", lines_done, 0);
      chk("midrst_out_result", out_result, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1;
      clear_stats();
      out_ready = 1;
      repeat (20) step();
      chk("midrst_no_stale", saw_valid, 0);
      run_job(5, 32'h40000000, 1, 100, 100, 0, 0);
      chk("post_rst_pops", pop_cnt, 5);
      chk("post_rst_done", done_cnt, 1);
      chk("post_rst_lines_done", lines_done, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
